// File: rtl/spi_target.sv
// spi_target: mode-0 SPI target port, fully oversampled in the clk domain.
// One-byte TX holding register, RX byte register and sticky error flags.
module spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_ss_n,
  input  logic       spi_sdi,
  output logic       spi_sdo,
  output logic       spi_sdo_en,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       selected,
  output logic       underrun,
  output logic       overrun,
  input  logic       clear_flags
);

  localparam int LAST = SYNC_STAGES - 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [LAST:0] sck_sync_q, sck_sync_d;
  logic [LAST:0] ss_sync_q, ss_sync_d;
  logic [LAST:0] sdi_sync_q, sdi_sync_d;
  logic          sck_last_q, ss_last_q;

  logic       sck_s, ss_s, sdi_s;
  logic       sck_rise, sck_fall;
  logic       ss_rise, ss_fall;

  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       pend_q, pend_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       underrun_q, underrun_d;
  logic       overrun_q, overrun_d;

  logic       active;
  logic       accept;
  logic       load_sel, load_next, load;
  logic       bit_rise, complete;
  logic       set_underrun, set_overrun;
  logic [7:0] rx_byte;

  // Synchroniser shift chains; new pin value enters at bit 0.
  always_comb begin
    sck_sync_d = {sck_sync_q[LAST-1:0], spi_sck};
    ss_sync_d  = {ss_sync_q[LAST-1:0], spi_ss_n};
    sdi_sync_d = {sdi_sync_q[LAST-1:0], spi_sdi};
  end

  // Synchronised levels and single-cycle edge pulses.
  always_comb begin
    sck_s    = sck_sync_q[LAST];
    ss_s     = ss_sync_q[LAST];
    sdi_s    = sdi_sync_q[LAST];
    sck_rise = sck_s & ~sck_last_q;
    sck_fall = ~sck_s & sck_last_q;
    ss_fall  = ~ss_s & ss_last_q;
    ss_rise  = ss_s & ~ss_last_q;
  end

  // Event decode shared by the datapath processes.
  always_comb begin
    active    = (state_q == ACTIVE);
    accept    = tx_valid & ~hold_full_q;
    load_sel  = ~active & ss_fall;
    load_next = active & ~ss_rise & sck_fall & pend_q;
    load      = load_sel | load_next;
    bit_rise  = active & ~ss_rise & sck_rise;
    complete  = bit_rise & (bit_cnt_q == 3'd7);
    rx_byte   = {rx_shift_q, sdi_s};
  end

  // Next-state logic: select edges move between IDLE and ACTIVE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ss_fall) state_d = ACTIVE;
      ACTIVE:  if (ss_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Holding register: capture when empty, drain on a TX load.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (load && hold_full_q) begin
      hold_full_d = 1'b0;
    end else if (accept && !load) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  // TX shifter: load (hold, forwarded byte or idle fill), else shift on fall.
  always_comb begin
    tx_shift_d   = tx_shift_q;
    set_underrun = 1'b0;
    if (load) begin
      if (hold_full_q) begin
        tx_shift_d = hold_q;
      end else if (accept) begin
        tx_shift_d = tx_data;
      end else begin
        tx_shift_d   = IDLE_BYTE;
        set_underrun = 1'b1;
      end
    end else if (active && sck_fall) begin
      tx_shift_d = {tx_shift_q[6:0], 1'b1};
    end
  end

  // Bit counter, RX shifter and the reload-pending marker.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    pend_d     = pend_q;
    rx_shift_d = rx_shift_q;
    if (!active || ss_rise) begin
      bit_cnt_d = 3'd0;
      pend_d    = 1'b0;
    end else begin
      if (bit_rise) begin
        bit_cnt_d  = bit_cnt_q + 3'd1;
        rx_shift_d = rx_byte[6:0];
        if (bit_cnt_q == 3'd7) pend_d = 1'b1;
      end
      if (load_next) pend_d = 1'b0;
    end
  end

  // RX byte register; the newest completed byte always wins.
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q & ~rx_ack;
    set_overrun = complete & rx_valid_q & ~rx_ack;
    if (complete) begin
      rx_data_d  = rx_byte;
      rx_valid_d = 1'b1;
    end
  end

  // Sticky flags; clearing beats a same-cycle set.
  always_comb begin
    underrun_d = ~clear_flags & (underrun_q | set_underrun);
    overrun_d  = ~clear_flags & (overrun_q | set_overrun);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Synchronisers preset to an idle bus: sck low, select released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync_q <= '0;
      ss_sync_q  <= '1;
      sdi_sync_q <= '0;
      sck_last_q <= 1'b0;
      ss_last_q  <= 1'b1;
    end else begin
      sck_sync_q <= sck_sync_d;
      ss_sync_q  <= ss_sync_d;
      sdi_sync_q <= sdi_sync_d;
      sck_last_q <= sck_s;
      ss_last_q  <= ss_s;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      tx_shift_q  <= IDLE_BYTE;
      rx_shift_q  <= 7'h00;
      bit_cnt_q   <= 3'd0;
      pend_q      <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      bit_cnt_q   <= bit_cnt_d;
      pend_q      <= pend_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
    end
  end

  // Pad and status outputs, all straight from flops.
  always_comb begin
    spi_sdo    = active ? tx_shift_q[7] : 1'b1;
    spi_sdo_en = active;
    selected   = active;
    tx_ready   = ~hold_full_q;
    rx_data    = rx_data_q;
    rx_valid   = rx_valid_q;
    underrun   = underrun_q;
    overrun    = overrun_q;
  end

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed and random frames against a byte-level model.
// The bench plays the external mode-0 SPI controller.
module tb_spi_target;

  localparam int         S    = 2;
  localparam int         H    = 8;
  localparam logic [7:0] IDLE = 8'hFF;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sck, spi_ss_n, spi_sdi;
  logic       spi_sdo, spi_sdo_en;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ack;
  logic       selected, underrun, overrun;
  logic       clear_flags;

  always #5 clk = ~clk;

  spi_target #(
    .SYNC_STAGES(S),
    .IDLE_BYTE  (IDLE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .spi_sck    (spi_sck),
    .spi_ss_n   (spi_ss_n),
    .spi_sdi    (spi_sdi),
    .spi_sdo    (spi_sdo),
    .spi_sdo_en (spi_sdo_en),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .selected   (selected),
    .underrun   (underrun),
    .overrun    (overrun),
    .clear_flags(clear_flags)
  );

  int vectors     = 0;
  int miscompares = 0;

  // byte-level reference state
  logic [7:0] hold_m;
  bit         hold_full_m;
  logic [7:0] rx_data_m;
  bit         rx_valid_m;
  bit         underrun_m;
  bit         overrun_m;
  bit         pend_m;
  logic [7:0] exp_out_m;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    hold_full_m = 0;
    rx_data_m   = 8'h00;
    rx_valid_m  = 0;
    underrun_m  = 0;
    overrun_m   = 0;
    pend_m      = 0;
  endtask

  // next byte to go out: the queued byte, else the idle fill
  task automatic m_load(output logic [7:0] b);
    if (hold_full_m) begin
      b = hold_m;
      hold_full_m = 0;
    end else begin
      b = IDLE;
      underrun_m = 1;
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".rx_data"},  rx_data,  rx_data_m);
    chk({tag, ".rx_valid"}, rx_valid, rx_valid_m);
    chk({tag, ".overrun"},  overrun,  overrun_m);
    chk({tag, ".underrun"}, underrun, underrun_m);
    chk({tag, ".tx_ready"}, tx_ready, !hold_full_m);
  endtask

  task automatic queue(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    hold_m = b;
    hold_full_m = 1;
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    rx_valid_m = 0;
  endtask

  task automatic clr();
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    underrun_m = 0;
    overrun_m  = 0;
  endtask

  // shift nbits MSB-first; sck is left high after the last bit
  task automatic xfer(input logic [7:0] mosi, input int nbits,
                      input bit q_en, input logic [7:0] qb,
                      input bit ack_mid, input bit ack_done,
                      output logic [7:0] miso);
    miso = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) spi_sck = 1'b0;
      spi_sdi = mosi[7-i];
      if (i == 3) begin
        if (q_en) begin
          tx_data  = qb;
          tx_valid = 1'b1;
          @(negedge clk);
          tx_valid = 1'b0;
        end
        if (ack_mid) begin
          rx_ack = 1'b1;
          @(negedge clk);
          rx_ack = 1'b0;
        end
      end
      repeat (H) @(negedge clk);
      miso[7-i] = spi_sdo;
      spi_sck = 1'b1;
      if (ack_done && i == 7) begin
        repeat (S) @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        repeat (H - S - 1) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
    end
  endtask

  task automatic select();
    spi_ss_n = 1'b0;
    m_load(exp_out_m);
    pend_m = 0;
  endtask

  task automatic run_byte(input string tag, input logic [7:0] mosi,
                          input bit q_en, input logic [7:0] qb,
                          input bit ack_mid, input bit ack_done);
    logic [7:0] miso;
    xfer(mosi, 8, q_en, qb, ack_mid, ack_done, miso);
    chk({tag, ".miso"}, miso, exp_out_m);
    if (q_en) begin
      hold_m = qb;
      hold_full_m = 1;
    end
    if (ack_mid) rx_valid_m = 0;
    if (rx_valid_m && !ack_done) overrun_m = 1;
    rx_data_m  = mosi;
    rx_valid_m = 1;
    pend_m     = 1;
    chk_status(tag);
    chk({tag, ".selected"}, selected, 1'b1);
    chk({tag, ".sdo_en"}, spi_sdo_en, 1'b1);
  endtask

  // falling sck edge; optionally offer a byte on the reload cycle
  task automatic sck_down(input bit fwd, input logic [7:0] fb);
    spi_sck = 1'b0;
    if (fwd) begin
      repeat (S) @(negedge clk);
      tx_data  = fb;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      hold_m = fb;
      hold_full_m = 1;
    end
    if (pend_m) begin
      m_load(exp_out_m);
      pend_m = 0;
    end
  endtask

  task automatic deselect(input string tag);
    sck_down(1'b0, 8'h00);
    repeat (H) @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (H) @(negedge clk);
    chk({tag, ".sel_off"}, selected, 1'b0);
    chk({tag, ".en_off"}, spi_sdo_en, 1'b0);
    chk({tag, ".sdo_idle"}, spi_sdo, 1'b1);
    chk_status(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] scratch;
    int         nb;
    bit         q_en, fwd;
    logic [7:0] qb;

    reset = 1'b1;
    spi_sck = 1'b0;
    spi_ss_n = 1'b1;
    spi_sdi = 1'b0;
    tx_data = 8'h00;
    tx_valid = 1'b0;
    rx_ack = 1'b0;
    clear_flags = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst.sdo", spi_sdo, 1'b1);
    chk("rst.sdo_en", spi_sdo_en, 1'b0);
    chk("rst.selected", selected, 1'b0);
    chk_status("rst");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // single byte with a queued TX byte
    queue(8'hA5);
    chk("t1.tx_ready_low", tx_ready, 1'b0);
    select();
    run_byte("t1", 8'h3C, 0, 8'h00, 0, 0);
    deselect("t1");

    // three-byte burst, only two bytes queued
    clr();
    ack();
    queue(8'h01);
    select();
    run_byte("t2a", 8'h11, 1, 8'h02, 0, 0);
    sck_down(0, 8'h00);
    run_byte("t2b", 8'h22, 0, 8'h00, 1, 0);
    sck_down(0, 8'h00);
    run_byte("t2c", 8'h33, 0, 8'h00, 1, 0);
    deselect("t2");
    clr();
    chk("t2.clear", underrun, 1'b0);

    // overrun, then ack coincident with completion
    ack();
    select();
    run_byte("t3a", 8'h5A, 0, 8'h00, 0, 0);
    sck_down(0, 8'h00);
    run_byte("t3b", 8'hC3, 0, 8'h00, 0, 0);
    deselect("t3");
    clr();
    select();
    run_byte("t3c", 8'h96, 0, 8'h00, 1, 0);
    sck_down(0, 8'h00);
    run_byte("t3d", 8'h69, 0, 8'h00, 0, 1);
    deselect("t3x");

    // aborted partial frame, then a clean frame
    ack();
    clr();
    select();
    xfer(8'hF0, 5, 0, 8'h00, 0, 0, scratch);
    deselect("t4p");
    select();
    run_byte("t4", 8'h81, 0, 8'h00, 0, 0);
    deselect("t4");

    // byte offered exactly on the reload cycle
    clr();
    queue(8'h11);
    select();
    run_byte("t5a", 8'h44, 0, 8'h00, 1, 0);
    sck_down(1, 8'h5A);
    run_byte("t5b", 8'h55, 0, 8'h00, 1, 0);
    deselect("t5");

    // reset in the middle of a byte
    clr();
    select();
    run_byte("t6a", 8'h77, 0, 8'h00, 1, 0);
    sck_down(0, 8'h00);
    xfer(8'hE7, 4, 0, 8'h00, 0, 0, scratch);
    reset = 1'b1;
    #1;
    chk("t6.sdo_en", spi_sdo_en, 1'b0);
    chk("t6.rx_valid", rx_valid, 1'b0);
    chk("t6.selected", selected, 1'b0);
    chk("t6.sdo", spi_sdo, 1'b1);
    spi_ss_n = 1'b1;
    spi_sck = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    queue(8'hC3);
    select();
    run_byte("t6b", 8'h3E, 0, 8'h00, 0, 0);
    deselect("t6");

    // random frames
    for (int f = 0; f < 8; f++) begin
      if ($urandom_range(0, 2) == 0) clr();
      if (!hold_full_m && $urandom_range(0, 1) == 1)
        queue(8'($urandom));
      select();
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        if (b > 0) begin
          fwd = !hold_full_m && ($urandom_range(0, 3) == 0);
          sck_down(fwd, 8'($urandom));
        end
        q_en = !hold_full_m && ($urandom_range(0, 1) == 1);
        qb   = 8'($urandom);
        run_byte("rnd", 8'($urandom), q_en, qb,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0);
      end
      deselect("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
